// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the encryption datapath.
// Used by mod_enc_mixcolumns and its column multiplier.
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef logic [15:0][7:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mixcol_fsm_t;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gmul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

endpackage

// File: rtl/mod_enc_mixcolumns_if.sv
// State-in / state-out handshake bundle for the MixColumns stage.
// The last_round signal exists only when MOD_ENC_MIXCOL_BYPASS_EN is defined.
interface mod_enc_mixcolumns_if;
  import aes_pkg::*;

  // Valid/ready: a transfer happens on a rising edge where valid && ready are
  // both high; the source holds valid and data stable until that edge.
  logic        in_valid;
  logic        in_ready;
  aes_state_t  p00;
`ifdef MOD_ENC_MIXCOL_BYPASS_EN
  logic        last_round;
`endif
  logic        out_valid;
  logic        out_ready;
  aes_state_t  o00;
  mixcol_fsm_t dbg_state;

  modport slave (
    input  in_valid, p00, out_ready,
`ifdef MOD_ENC_MIXCOL_BYPASS_EN
    input  last_round,
`endif
    output in_ready, out_valid, o00, dbg_state
  );

  modport master (
    output in_valid, p00, out_ready,
`ifdef MOD_ENC_MIXCOL_BYPASS_EN
    output last_round,
`endif
    input  in_ready, out_valid, o00, dbg_state
  );

endinterface

// File: rtl/mod_enc_mixcol_col.sv
// Combinational MixColumns on one 32-bit column; byte 0 (bits 7:0) is row 0.
module mod_enc_mixcol_col
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  logic [7:0] a0, a1, a2, a3;

  assign a0 = col_i[7:0];
  assign a1 = col_i[15:8];
  assign a2 = col_i[23:16];
  assign a3 = col_i[31:24];

  assign col_o[7:0]   = xtime(a0) ^ gmul3(a1) ^ a2 ^ a3;
  assign col_o[15:8]  = a0 ^ xtime(a1) ^ gmul3(a2) ^ a3;
  assign col_o[23:16] = a0 ^ a1 ^ xtime(a2) ^ gmul3(a3);
  assign col_o[31:24] = gmul3(a0) ^ a1 ^ a2 ^ xtime(a3);

endmodule

// File: rtl/mod_enc_mixcolumns.sv
// AES MixColumns stage: one column per clock through a single shared multiplier.
// Define MOD_ENC_MIXCOL_BYPASS_EN to add last_round, which skips mixing.
module mod_enc_mixcolumns
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  mod_enc_mixcolumns_if.slave  bus,
  output logic                 busy
);

  mixcol_fsm_t state_q, state_d;
  logic [1:0]  col_q, col_d;
  aes_state_t  buf_q, buf_d;
  logic [31:0] col_in, col_out;

  assign col_in = buf_q[{col_q, 2'b00} +: 4];

  mod_enc_mixcol_col u_col (
    .col_i (col_in),
    .col_o (col_out)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    buf_d   = buf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          buf_d = bus.p00;
          col_d = 2'd0;
`ifdef MOD_ENC_MIXCOL_BYPASS_EN
          if (bus.last_round) state_d = DONE;
          else
`endif
          state_d = CALC;
        end
      end
      CALC: begin
        buf_d[{col_q, 2'b00} +: 4] = col_out;
        // The 2-bit counter wraps to 0 on the final column, ready for the next state.
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Partially mixed buffers are never exposed; o00 is zero outside DONE.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.o00       = (state_q == DONE) ? buf_q : '0;
  assign bus.dbg_state = state_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mod_enc_mixcolumns.sv
// Directed bench for mod_enc_mixcolumns with hand-computed MixColumns vectors.
// Bypass steps run only when MOD_ENC_MIXCOL_BYPASS_EN is defined.
module tb_mod_enc_mixcolumns;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  mod_enc_mixcolumns_if bus ();

  mod_enc_mixcolumns dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_col(input logic [7:0] b0, input logic [7:0] b1,
                                         input logic [7:0] b2, input logic [7:0] b3);
    return {b3, b2, b1, b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic accept(input aes_state_t s);
    int n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    check("accept_ready", bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.p00      = s;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic retire();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("retire_idle", {bus.in_ready, bus.out_valid, busy}, 3'b100);
  endtask

  aes_state_t fips_in, fips_out, d4_in, d4_out, c6_st, seq_in, seq_out;
  int lat;
  int pulses;

  initial begin
    fips_in  = {mk_col(8'h2d, 8'h26, 8'h31, 8'h4c), mk_col(8'h01, 8'h01, 8'h01, 8'h01),
                mk_col(8'hf2, 8'h0a, 8'h22, 8'h5c), mk_col(8'hdb, 8'h13, 8'h53, 8'h45)};
    fips_out = {mk_col(8'h4d, 8'h7e, 8'hbd, 8'hf8), mk_col(8'h01, 8'h01, 8'h01, 8'h01),
                mk_col(8'h9f, 8'hdc, 8'h58, 8'h9d), mk_col(8'h8e, 8'h4d, 8'ha1, 8'hbc)};
    d4_in    = {4{mk_col(8'hd4, 8'hd4, 8'hd4, 8'hd5)}};
    d4_out   = {4{mk_col(8'hd5, 8'hd5, 8'hd7, 8'hd6)}};
    c6_st    = {16{8'hc6}};
    seq_in   = {mk_col(8'h0c, 8'h0d, 8'h0e, 8'h0f), mk_col(8'h08, 8'h09, 8'h0a, 8'h0b),
                mk_col(8'h04, 8'h05, 8'h06, 8'h07), mk_col(8'h00, 8'h01, 8'h02, 8'h03)};
    seq_out  = {mk_col(8'h0e, 8'h0b, 8'h0c, 8'h09), mk_col(8'h0a, 8'h0f, 8'h08, 8'h0d),
                mk_col(8'h06, 8'h03, 8'h04, 8'h01), mk_col(8'h02, 8'h07, 8'h00, 8'h05)};

    // Step 1: reset held with in_valid high; nothing may be captured.
    bus.in_valid  = 1'b1;
    bus.p00       = fips_in;
    bus.out_ready = 1'b0;
`ifdef MOD_ENC_MIXCOL_BYPASS_EN
    bus.last_round = 1'b0;
`endif
    rst = 1'b0;
    tick();
    tick();
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_o00", bus.o00, 128'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", bus.dbg_state, IDLE);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("post_rst_busy", busy, 1'b0);

    // Step 2: FIPS-197 MixColumns vector, 4-cycle latency.
    accept(fips_in);
    check("fips_busy", {busy, bus.in_ready}, 2'b10);
    check("fips_state", bus.dbg_state, CALC);
    wait_out(lat);
    check("fips_latency", lat, 4);
    check("fips_o00", bus.o00, fips_out);
    retire();

    // Step 3: backpressure holds the result stable.
    accept(d4_in);
    wait_out(lat);
    check("d4_latency", lat, 4);
    for (int i = 0; i < 6; i++) begin
      check("stall_valid", bus.out_valid, 1'b1);
      check("stall_o00", bus.o00, d4_out);
      check("stall_in_ready", bus.in_ready, 1'b0);
      tick();
    end
    retire();

    // Step 4: reset two cycles into CALC drops the state in flight.
    accept(fips_in);
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midrst_state", bus.dbg_state, IDLE);
    check("midrst_o00", bus.o00, 128'h0);
    check("midrst_busy", busy, 1'b0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.out_valid) pulses++;
      tick();
    end
    check("midrst_no_pulse", pulses, 0);

    // Step 5: in_valid during CALC is ignored.
    accept(c6_st);
    tick();
    bus.in_valid = 1'b1;
    bus.p00      = fips_in;
    tick();
    bus.in_valid = 1'b0;
    wait_out(lat);
    check("busy_in_latency", lat, 2);
    check("busy_in_o00", bus.o00, c6_st);
    retire();
    check("busy_in_no_reaccept", busy, 1'b0);

    // Step 6: mixed result for 00..0f, then bypass when available.
    accept(seq_in);
    wait_out(lat);
    check("seq_latency", lat, 4);
    check("seq_o00", bus.o00, seq_out);
    retire();
`ifdef MOD_ENC_MIXCOL_BYPASS_EN
    bus.last_round = 1'b1;
    accept(seq_in);
    bus.last_round = 1'b0;
    check("byp_valid", bus.out_valid, 1'b1);
    check("byp_o00", bus.o00, seq_in);
    retire();
    accept(seq_in);
    wait_out(lat);
    check("nobyp_latency", lat, 4);
    check("nobyp_o00", bus.o00, seq_out);
    retire();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
